// File: rtl/ascon_stream_ctrl_pkg.sv
// ascon_ctrl_pkg
// Shared definitions for the Ascon stream controller: datapath widths,
// block-counter width and the controller state encoding.
package ascon_ctrl_pkg;

  localparam int BLOCK_W = 64;   // one Ascon rate block
  localparam int KEY_W   = 128;  // key and nonce width
  localparam int TAG_W   = 128;  // authentication tag width
  localparam int CNT_W   = 5;    // block counter width (up to 31 blocks)

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    INIT      = 4'd1,
    INIT_WAIT = 4'd2,
    AD_SEND   = 4'd3,
    AD_WAIT   = 4'd4,
    PT_SEND   = 4'd5,
    PT_WAIT   = 4'd6,
    FIN_SEND  = 4'd7,
    FIN_WAIT  = 4'd8,
    DONE      = 4'd9
  } ascon_state_t;

endpackage

// File: rtl/ascon_stream_ctrl_if.sv
// ascon_stream_ctrl_if
// Bundle of the controller <-> Ascon core handshake. The controller keeps
// flat ports so it drops into existing integrations unchanged; this bundle
// gives the integration level (and any core model) one object to route.
//
// Handshake: every *_SEND strobe (init, associate_data, finalisation with
// data_valid) is a single-cycle command, the core acknowledges each with a
// single-cycle end_* pulse; cipher_valid qualifies cipher in the same cycle
// and may coincide with end_cipher. There is no backpressure on commands.
//
// Modports:
//   master - controller side: drives commands and data, receives core status
//   slave  - core side: receives commands and data, drives status and results
interface ascon_stream_ctrl_if
  import ascon_ctrl_pkg::*;
;
  logic               init;
  logic               associate_data;
  logic               finalisation;
  logic               data_valid;
  logic [BLOCK_W-1:0] data;
  logic               end_initialisation;
  logic               end_associate;
  logic               cipher_valid;
  logic               end_cipher;
  logic               end_tag;
  logic [BLOCK_W-1:0] cipher;
  logic [TAG_W-1:0]   tag;

  modport master (
    output init, associate_data, finalisation, data_valid, data,
    input  end_initialisation, end_associate, cipher_valid, end_cipher,
    input  end_tag, cipher, tag
  );

  modport slave (
    input  init, associate_data, finalisation, data_valid, data,
    output end_initialisation, end_associate, cipher_valid, end_cipher,
    output end_tag, cipher, tag
  );

endinterface

// File: rtl/ascon_stream_ctrl_counter.sv
// compteur_Nbits
// Plain N-bit up counter with synchronous clear and increment enable.
// Clear has priority over increment so a "step and restart" request
// lands on zero.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clear       - synchronous clear to 0
//   incr        - synchronous increment by 1
//   count       - current value
module compteur_Nbits #(
  parameter int N_bits = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              incr,
  output logic [N_bits-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (incr) begin
      count <= count + N_bits'(1);
    end
  end

endmodule

// File: rtl/ascon_stream_ctrl.sv
// ascon_stream_ctrl
// Sequences one Ascon AEAD message through an external core: initialisation,
// n_ad associated-data blocks, n_blocks-1 plaintext blocks, then the last
// block with finalisation. Each ciphertext block returned by the core is
// stored at its block index in cipher_o; the tag is stored on end_tag_i.
// Message lengths are checked when the start is accepted; a bad length goes
// straight to DONE with err_o set and never touches the core.
//
// Ports:
//   clock_i, reset_i        - clock, asynchronous active-low reset
//   start_i                 - start request (only looked at in IDLE)
//   n_blocks_i, n_ad_i      - plaintext / associated-data block counts
//   plain_text_i, da_i      - message blocks, block 0 in the MSBs
//   key_i, nonce_i          - routed to the core by the integration level
//   init_o, associate_data_o, finalisation_o, data_valid_o, data_o
//                           - single-cycle commands to the core
//   end_initialisation_i, end_associate_i, cipher_valid_i, end_cipher_i,
//   end_tag_i, cipher_i, tag_i
//                           - core status and results
//   cipher_o, tag_o         - registered results, block 0 in the MSBs
//   busy_o                  - high outside IDLE
//   done_o, err_o           - end-of-message pulse and its error flag
//   state_o                 - current controller state (observability)
module ascon_stream_ctrl
  import ascon_ctrl_pkg::*;
#(
  parameter int MAX_BLOCKS = 23,
  parameter int MAX_AD     = 2
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic                          start_i,
  input  logic [4:0]                    n_blocks_i,
  input  logic [2:0]                    n_ad_i,
  input  logic [BLOCK_W*MAX_BLOCKS-1:0] plain_text_i,
  input  logic [BLOCK_W*MAX_AD-1:0]     da_i,
  input  logic [KEY_W-1:0]              key_i,
  input  logic [KEY_W-1:0]              nonce_i,
  output logic                          init_o,
  output logic                          associate_data_o,
  output logic                          finalisation_o,
  output logic                          data_valid_o,
  output logic [BLOCK_W-1:0]            data_o,
  input  logic                          end_initialisation_i,
  input  logic                          end_associate_i,
  input  logic                          cipher_valid_i,
  input  logic                          end_cipher_i,
  input  logic                          end_tag_i,
  input  logic [BLOCK_W-1:0]            cipher_i,
  input  logic [TAG_W-1:0]              tag_i,
  output logic [BLOCK_W*MAX_BLOCKS-1:0] cipher_o,
  output logic [TAG_W-1:0]              tag_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_o,
  output ascon_state_t                  state_o
);

  localparam logic [CNT_W-1:0] MAX_BLK_L = CNT_W'(MAX_BLOCKS);
  localparam logic [2:0]       MAX_AD_L  = 3'(MAX_AD);

  ascon_state_t     state;
  logic [CNT_W-1:0] n_blocks_q;
  logic [2:0]       n_ad_q;
  logic             err_q;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] last_idx;
  logic             cnt_clear;
  logic             cnt_incr;

  logic             start_bad;
  logic             ad_more;
  ascon_state_t     data_phase;

  // Packed views: element MAX-1 sits in the MSBs, so block k is element MAX-1-k.
  logic [MAX_BLOCKS-1:0][BLOCK_W-1:0] pt_blk;
  logic [MAX_AD-1:0][BLOCK_W-1:0]     ad_blk;
  logic [MAX_BLOCKS-1:0][BLOCK_W-1:0] cipher_q;

  logic [CNT_W-1:0] pt_idx;
  logic [BLOCK_W-1:0] pt_sel;
  logic [BLOCK_W-1:0] ad_sel;
  logic             cipher_we;
  logic [CNT_W-1:0] cipher_idx;

  // Key and nonce go to the core directly at the integration level; they
  // are carried here only so the controller owns the whole message context.
  logic unused_key_nonce;
  assign unused_key_nonce = ^{key_i, nonce_i};

  assign pt_blk   = plain_text_i;
  assign ad_blk   = da_i;
  assign cipher_o = cipher_q;

  assign cnt_inc  = cnt + CNT_W'(1);
  assign last_idx = n_blocks_q - CNT_W'(1);

  assign start_bad = (n_blocks_i == '0) || (n_blocks_i > MAX_BLK_L) ||
                     (n_ad_i > MAX_AD_L);

  assign ad_more = cnt_inc < {2'b00, n_ad_q};

  // A single-block message has no plaintext-only blocks: its only block is
  // the finalisation block.
  assign data_phase = (n_blocks_q > CNT_W'(1)) ? PT_SEND : FIN_SEND;

  compteur_Nbits #(
    .N_bits(CNT_W)
  ) u_blk_cnt (
    .clk   (clock_i),
    .rst_n (reset_i),
    .clear (cnt_clear),
    .incr  (cnt_incr),
    .count (cnt)
  );

  // Counter control: cleared on start and between the AD and data phases,
  // stepped on each AD or plaintext acknowledgement.
  always_comb begin
    cnt_clear = 1'b0;
    cnt_incr  = 1'b0;
    case (state)
      IDLE: cnt_clear = start_i;
      AD_WAIT: begin
        if (end_associate_i) begin
          cnt_incr  = 1'b1;
          cnt_clear = !ad_more;
        end
      end
      PT_WAIT: cnt_incr = end_cipher_i;
      default: ;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state      <= IDLE;
      n_blocks_q <= '0;
      n_ad_q     <= '0;
      err_q      <= 1'b0;
      tag_o      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            n_blocks_q <= n_blocks_i;
            n_ad_q     <= n_ad_i;
            tag_o      <= '0;
            err_q      <= start_bad;
            state      <= start_bad ? DONE : INIT;
          end
        end
        INIT: state <= INIT_WAIT;
        INIT_WAIT: begin
          if (end_initialisation_i) begin
            state <= (n_ad_q != 3'd0) ? AD_SEND : data_phase;
          end
        end
        AD_SEND: state <= AD_WAIT;
        AD_WAIT: begin
          if (end_associate_i) begin
            state <= ad_more ? AD_SEND : data_phase;
          end
        end
        PT_SEND: state <= PT_WAIT;
        PT_WAIT: begin
          if (end_cipher_i) begin
            state <= (cnt_inc == last_idx) ? FIN_SEND : PT_SEND;
          end
        end
        FIN_SEND: state <= FIN_WAIT;
        FIN_WAIT: begin
          if (end_tag_i) begin
            tag_o <= tag_i;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Ciphertext capture. The last block is addressed explicitly because the
  // counter stays at 0 for single-block messages.
  assign cipher_we  = cipher_valid_i && ((state == PT_WAIT) || (state == FIN_WAIT));
  assign cipher_idx = (state == FIN_WAIT) ? last_idx : cnt;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      cipher_q <= '0;
    end else if ((state == IDLE) && start_i) begin
      cipher_q <= '0;
    end else if (cipher_we) begin
      for (int i = 0; i < MAX_BLOCKS; i++) begin
        if (cipher_idx == CNT_W'(i)) begin
          cipher_q[MAX_BLOCKS-1-i] <= cipher_i;
        end
      end
    end
  end

  // Block selection for data_o.
  assign pt_idx = (state == FIN_SEND) ? last_idx : cnt;

  always_comb begin
    pt_sel = '0;
    ad_sel = '0;
    for (int i = 0; i < MAX_BLOCKS; i++) begin
      if (pt_idx == CNT_W'(i)) pt_sel = pt_blk[MAX_BLOCKS-1-i];
    end
    for (int i = 0; i < MAX_AD; i++) begin
      if (cnt == CNT_W'(i)) ad_sel = ad_blk[MAX_AD-1-i];
    end
  end

  // Core commands are a pure decode of the state register.
  always_comb begin
    init_o           = 1'b0;
    associate_data_o = 1'b0;
    finalisation_o   = 1'b0;
    data_valid_o     = 1'b0;
    data_o           = '0;
    case (state)
      INIT: init_o = 1'b1;
      AD_SEND: begin
        associate_data_o = 1'b1;
        data_valid_o     = 1'b1;
        data_o           = ad_sel;
      end
      PT_SEND: begin
        data_valid_o = 1'b1;
        data_o       = pt_sel;
      end
      FIN_SEND: begin
        finalisation_o = 1'b1;
        data_valid_o   = 1'b1;
        data_o         = pt_sel;
      end
      default: ;
    endcase
  end

  assign busy_o  = (state != IDLE);
  assign done_o  = (state == DONE);
  assign err_o   = done_o && err_q;
  assign state_o = state;

endmodule

// File: tb/tb_ascon_stream_ctrl.sv
`timescale 1ns/1ps
module tb_ascon_stream_ctrl;
  import ascon_ctrl_pkg::*;

  localparam int MAX_BLOCKS = 23;
  localparam int MAX_AD     = 2;
  localparam int LAT        = 3;
  localparam logic [63:0]  C_MASK = 64'h5A3C_96F0_0FF0_C3A5;
  localparam logic [127:0] KEY    = 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF;
  localparam logic [127:0] NONCE  = 128'hF0E1_D2C3_B4A5_9687_7869_5A4B_3C2D_1E0F;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT connections ----------------
  logic                          start;
  logic [4:0]                    n_blocks;
  logic [2:0]                    n_ad;
  logic [64*MAX_BLOCKS-1:0]      plain_text;
  logic [64*MAX_AD-1:0]          da;
  logic [127:0]                  key;
  logic [127:0]                  nonce;
  logic [64*MAX_BLOCKS-1:0]      cipher_o;
  logic [127:0]                  tag_o;
  logic                          busy;
  logic                          done;
  logic                          err;
  ascon_state_t                  state;

  ascon_stream_ctrl_if core_if ();

  ascon_stream_ctrl #(
    .MAX_BLOCKS (MAX_BLOCKS),
    .MAX_AD     (MAX_AD)
  ) dut (
    .clock_i              (clk),
    .reset_i              (rst_n),
    .start_i              (start),
    .n_blocks_i           (n_blocks),
    .n_ad_i               (n_ad),
    .plain_text_i         (plain_text),
    .da_i                 (da),
    .key_i                (key),
    .nonce_i              (nonce),
    .init_o               (core_if.init),
    .associate_data_o     (core_if.associate_data),
    .finalisation_o       (core_if.finalisation),
    .data_valid_o         (core_if.data_valid),
    .data_o               (core_if.data),
    .end_initialisation_i (core_if.end_initialisation),
    .end_associate_i      (core_if.end_associate),
    .cipher_valid_i       (core_if.cipher_valid),
    .end_cipher_i         (core_if.end_cipher),
    .end_tag_i            (core_if.end_tag),
    .cipher_i             (core_if.cipher),
    .tag_i                (core_if.tag),
    .cipher_o             (cipher_o),
    .tag_o                (tag_o),
    .busy_o               (busy),
    .done_o               (done),
    .err_o                (err),
    .state_o              (state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- stimulus data ----------------
  logic [63:0] pt_seed;

  function automatic logic [63:0] pt_word(input int i);
    return {16'hB10C, 16'(i), 32'hC0DE_0000 + 32'(i)} ^ pt_seed;
  endfunction

  function automatic logic [63:0] ad_word(input int i);
    return {16'hADAD, 16'(i), 32'h0000_5EED} ^ pt_seed;
  endfunction

  function automatic logic [63:0] cipher_blk(input int i);
    return cipher_o[64*(MAX_BLOCKS-1-i) +: 64];
  endfunction

  task automatic load_inputs(input logic [63:0] seed);
    pt_seed = seed;
    for (int i = 0; i < MAX_BLOCKS; i++) plain_text[64*(MAX_BLOCKS-1-i) +: 64] = pt_word(i);
    for (int i = 0; i < MAX_AD; i++) da[64*(MAX_AD-1-i) +: 64] = ad_word(i);
  endtask

  // ---------------- scoreboard + core model ----------------
  logic [63:0] exp_q[$];
  int init_cnt, ad_cnt, pt_cnt, fin_cnt, done_cnt, err_cnt;
  int same_blk = -1;

  typedef enum {K_NONE, K_INIT, K_AD, K_PT, K_FIN} kind_t;
  kind_t       pend_kind;
  int          pend_t;
  int          stage2;
  int          pt_idx;
  logic [63:0] pend_data;

  task automatic clear_counts();
    init_cnt = 0; ad_cnt = 0; pt_cnt = 0; fin_cnt = 0; done_cnt = 0; err_cnt = 0;
  endtask

  // Core with LAT-cycle response latency; everything driven on negedge.
  initial begin
    logic [63:0] e;
    core_if.end_initialisation = 1'b0;
    core_if.end_associate      = 1'b0;
    core_if.cipher_valid       = 1'b0;
    core_if.end_cipher         = 1'b0;
    core_if.end_tag            = 1'b0;
    core_if.cipher             = '0;
    core_if.tag                = '0;
    pend_kind = K_NONE; pend_t = 0; stage2 = 0; pt_idx = 0; pend_data = '0;
    forever begin
      @(negedge clk);
      core_if.end_initialisation = 1'b0;
      core_if.end_associate      = 1'b0;
      core_if.cipher_valid       = 1'b0;
      core_if.end_cipher         = 1'b0;
      core_if.end_tag            = 1'b0;
      if (!rst_n) begin
        pend_kind = K_NONE;
        stage2    = 0;
        continue;
      end
      if (done) done_cnt++;
      if (err) err_cnt++;
      // pending responses
      if (stage2 == 1) begin
        core_if.end_cipher = 1'b1;
        stage2 = 0;
      end else if (stage2 == 2) begin
        core_if.end_tag = 1'b1;
        core_if.tag     = KEY ^ NONCE;
        stage2 = 0;
      end else if (pend_kind != K_NONE) begin
        pend_t--;
        if (pend_t == 0) begin
          case (pend_kind)
            K_INIT: core_if.end_initialisation = 1'b1;
            K_AD:   core_if.end_associate = 1'b1;
            K_PT: begin
              core_if.cipher_valid = 1'b1;
              core_if.cipher       = pend_data ^ C_MASK;
              if (pt_idx == same_blk) core_if.end_cipher = 1'b1;
              else stage2 = 1;
              pt_idx++;
            end
            K_FIN: begin
              core_if.cipher_valid = 1'b1;
              core_if.cipher       = pend_data ^ C_MASK;
              stage2 = 2;
            end
            default: ;
          endcase
          pend_kind = K_NONE;
        end
      end
      // new commands from the DUT
      if (core_if.init) begin
        init_cnt++;
        pt_idx    = 0;
        pend_kind = K_INIT;
        pend_t    = LAT;
      end
      if (core_if.data_valid) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
        check("data", {64'd0, core_if.data}, {64'd0, e});
        if (core_if.associate_data) begin
          ad_cnt++;
          pend_kind = K_AD;
        end else if (core_if.finalisation) begin
          fin_cnt++;
          pend_kind = K_FIN;
        end else begin
          pt_cnt++;
          pend_kind = K_PT;
        end
        pend_data = core_if.data;
        pend_t    = LAT;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_expected(input int nb, input int na);
    for (int a = 0; a < na; a++) exp_q.push_back(ad_word(a));
    for (int p = 0; p < nb - 1; p++) exp_q.push_back(pt_word(p));
    exp_q.push_back(pt_word(nb - 1));
  endtask

  task automatic start_msg(input int nb, input int na);
    @(negedge clk);
    n_blocks = 5'(nb);
    n_ad     = 3'(na);
    start    = 1'b1;
    push_expected(nb, na);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < budget && !seen; c++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check(tag, {127'd0, seen}, 128'd1);
  endtask

  task automatic check_cipher(input string tag, input int nb);
    for (int i = 0; i < MAX_BLOCKS; i++) begin
      if (i < nb) check($sformatf("%s_blk%0d", tag, i), {64'd0, cipher_blk(i)}, {64'd0, pt_word(i) ^ C_MASK});
      else        check($sformatf("%s_blk%0d", tag, i), {64'd0, cipher_blk(i)}, 128'd0);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_state"}, 128'(state), 128'(IDLE));
    check({tag, "_busy"},  {127'd0, busy}, 128'd0);
    check({tag, "_done"},  {127'd0, done}, 128'd0);
    check({tag, "_err"},   {127'd0, err}, 128'd0);
    check({tag, "_strobes"}, {124'd0, core_if.init, core_if.associate_data,
                              core_if.finalisation, core_if.data_valid}, 128'd0);
    check({tag, "_data"},  {64'd0, core_if.data}, 128'd0);
  endtask

  task automatic bad_start(input string tag, input int nb, input int na);
    clear_counts();
    @(negedge clk);
    n_blocks = 5'(nb);
    n_ad     = 3'(na);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_done"},  {127'd0, done}, 128'd1);
    check({tag, "_err"},   {127'd0, err}, 128'd1);
    check({tag, "_init"},  {127'd0, core_if.init}, 128'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, {127'd0, done}, 128'd0);
    check({tag, "_busy"}, {127'd0, busy}, 128'd0);
    check({tag, "_init_cnt"}, 128'(init_cnt), 128'd0);
    check({tag, "_cipher_clr"}, {127'd0, |cipher_o}, 128'd0);
    check({tag, "_tag_clr"}, tag_o, 128'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    start = 1'b0; n_blocks = '0; n_ad = '0;
    key = KEY; nonce = NONCE;
    plain_text = '0; da = '0;
    load_inputs(64'h0);
    clear_counts();
    rst_n = 1'b0;
    @(negedge clk);
    check_idle_outputs("rst");
    check("rst_cipher", {127'd0, |cipher_o}, 128'd0);
    check("rst_tag", tag_o, 128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Full-length message with one AD block.
    load_inputs(64'h1357_9BDF_0246_8ACE);
    same_blk = -1;
    clear_counts();
    start_msg(23, 1);
    wait_done("A_done_seen", 2000);
    check("A_err", {127'd0, err}, 128'd0);
    @(negedge clk);
    check("A_init_cnt", 128'(init_cnt), 128'd1);
    check("A_ad_cnt",   128'(ad_cnt),   128'd1);
    check("A_pt_cnt",   128'(pt_cnt),   128'd22);
    check("A_fin_cnt",  128'(fin_cnt),  128'd1);
    check("A_done_cnt", 128'(done_cnt), 128'd1);
    check("A_err_cnt",  128'(err_cnt),  128'd0);
    check("A_exp_empty", 128'(exp_q.size()), 128'd0);
    check("A_tag", tag_o, KEY ^ NONCE);
    check_cipher("A", 23);
    check_idle_outputs("A_after");

    // Two AD blocks; block 5 answered with cipher_valid and end_cipher together.
    load_inputs(64'h0F0F_1234_ABCD_5555);
    same_blk = 5;
    clear_counts();
    start_msg(8, 2);
    wait_done("B_done_seen", 1000);
    @(negedge clk);
    same_blk = -1;
    check("B_ad_cnt",  128'(ad_cnt),  128'd2);
    check("B_pt_cnt",  128'(pt_cnt),  128'd7);
    check("B_fin_cnt", 128'(fin_cnt), 128'd1);
    check("B_exp_empty", 128'(exp_q.size()), 128'd0);
    check_cipher("B", 8);

    // Single block, no AD: straight from INIT_WAIT to finalisation.
    load_inputs(64'hFFFF_0000_1111_2222);
    clear_counts();
    start_msg(1, 0);
    wait_done("C_done_seen", 500);
    check("C_err", {127'd0, err}, 128'd0);
    @(negedge clk);
    check("C_init_cnt", 128'(init_cnt), 128'd1);
    check("C_ad_cnt",   128'(ad_cnt),   128'd0);
    check("C_pt_cnt",   128'(pt_cnt),   128'd0);
    check("C_fin_cnt",  128'(fin_cnt),  128'd1);
    check("C_exp_empty", 128'(exp_q.size()), 128'd0);
    check("C_tag", tag_o, KEY ^ NONCE);
    check_cipher("C", 1);

    // Rejected lengths.
    bad_start("D_nb0", 0, 0);
    bad_start("D_ad_over", 4, MAX_AD + 1);
    bad_start("D_nb_over", MAX_BLOCKS + 1, 0);

    // Reset while waiting on plaintext block 10.
    load_inputs(64'h2468_ACE0_1357_9BDF);
    clear_counts();
    start_msg(23, 0);
    begin
      bit hit;
      hit = 1'b0;
      for (int c = 0; c < 1000 && !hit; c++) begin
        @(negedge clk);
        if (pt_cnt == 11 && state == PT_WAIT) hit = 1'b1;
      end
      check("E_reached_blk10", {127'd0, hit}, 128'd1);
    end
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("E_rst");
    check("E_rst_cipher", {127'd0, |cipher_o}, 128'd0);
    check("E_rst_tag", tag_o, 128'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_counts();
    start_msg(4, 0);
    wait_done("E_done_seen", 500);
    check("E_err", {127'd0, err}, 128'd0);
    @(negedge clk);
    check("E_pt_cnt",  128'(pt_cnt),  128'd3);
    check("E_fin_cnt", 128'(fin_cnt), 128'd1);
    check("E_exp_empty", 128'(exp_q.size()), 128'd0);
    check("E_tag", tag_o, KEY ^ NONCE);
    check_cipher("E", 4);

    // start held high across a whole message.
    load_inputs(64'h7777_8888_9999_AAAA);
    clear_counts();
    @(negedge clk);
    n_blocks = 5'd2;
    n_ad     = 3'd0;
    start    = 1'b1;
    push_expected(2, 0);
    push_expected(2, 0);
    wait_done("F_done1_seen", 500);
    @(negedge clk);
    check("F_idle_between", 128'(state), 128'(IDLE));
    check("F_init_cnt1", 128'(init_cnt), 128'd1);
    @(negedge clk);
    check("F_restart", 128'(state), 128'(INIT));
    wait_done("F_done2_seen", 500);
    start = 1'b0;
    @(negedge clk);
    check("F_init_cnt2", 128'(init_cnt), 128'd2);
    check("F_done_cnt",  128'(done_cnt), 128'd2);
    check("F_err_cnt",   128'(err_cnt),  128'd0);
    check("F_exp_empty", 128'(exp_q.size()), 128'd0);
    check_cipher("F", 2);
    @(negedge clk);
    check("F_stays_idle", 128'(state), 128'(IDLE));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
